// File: rtl/alu_cu_pkg.sv
// ALU control unit shared definitions: operation codes, decoder class and funct encodings.
// Imported by the decoder and the registered top level.
package alu_cu_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111
    } alu_code_e;

    localparam logic [1:0] ALUOP_LS  = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_RSV = 2'b11;

    localparam logic [1:0] F3_ADDSUB = 2'b00;
    localparam logic [1:0] F3_SLT    = 2'b01;
    localparam logic [1:0] F3_OR     = 2'b10;
    localparam logic [1:0] F3_AND    = 2'b11;

    localparam logic [1:0] F7_NORM   = 2'b00;
    localparam logic [1:0] F7_ALT    = 2'b01;

    localparam alu_code_e ALU_RST_CODE = ALU_ADD;

endpackage

// File: rtl/alu_cu_dec.sv
// Combinational ALU operation decoder; zero latency, no flow control.
// Unsupported encodings fall back to ADD and raise illegal.
module alu_cu_dec
    import alu_cu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [1:0] f3,
    input  logic [1:0] f7,
    output logic [3:0] code,
    output logic       illegal
);

    alu_code_e w_code;
    logic      w_illegal;

    // funct fields are only examined in the R-type arm, so X on them cannot leak for load/store or branch.
    always_comb begin
        w_code    = ALU_ADD;
        w_illegal = 1'b0;
        case (alu_op)
            ALUOP_LS: w_code = ALU_ADD;
            ALUOP_BR: w_code = ALU_SUB;
            ALUOP_R: begin
                if (f7 == F7_NORM) begin
                    case (f3)
                        F3_ADDSUB: w_code = ALU_ADD;
                        F3_SLT:    w_code = ALU_SLT;
                        F3_OR:     w_code = ALU_OR;
                        F3_AND:    w_code = ALU_AND;
                        default:   w_illegal = 1'b1;
                    endcase
                end else if ((f7 == F7_ALT) && (f3 == F3_ADDSUB)) begin
                    w_code = ALU_SUB;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign code    = w_code;
    assign illegal = w_illegal;

endmodule

// File: rtl/alu_cu.sv
// Registered ALU control unit: one-cycle latency, always ready (no backpressure).
// Output illegal and its register exist only when ALU_CU_ILLEGAL_EN is defined.
module alu_cu
    import alu_cu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] alu_op,
    input  logic [1:0] f3,
    input  logic [1:0] f7,
    input  logic       in_valid,
    output logic [3:0] control_i,
    output logic       out_valid
`ifdef ALU_CU_ILLEGAL_EN
    ,
    output logic       illegal
`endif
);

    logic [3:0] w_code;
    logic [3:0] r_code;
    logic       r_vld;

`ifdef ALU_CU_ILLEGAL_EN
    logic w_ill;
    logic r_ill;
`else
    logic w_unused_ill;
`endif

    alu_cu_dec u_dec (
        .alu_op  (alu_op),
        .f3      (f3),
        .f7      (f7),
        .code    (w_code),
`ifdef ALU_CU_ILLEGAL_EN
        .illegal (w_ill)
`else
        .illegal (w_unused_ill)
`endif
    );

    // Code holds across idle cycles; only the valid flag drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code <= ALU_RST_CODE;
            r_vld  <= 1'b0;
        end else begin
            r_vld <= in_valid;
            if (in_valid) begin
                r_code <= w_code;
            end
        end
    end

`ifdef ALU_CU_ILLEGAL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ill <= 1'b0;
        end else if (in_valid) begin
            r_ill <= w_ill;
        end
    end

    assign illegal = r_ill;
`endif

    assign control_i = r_code;
    assign out_valid = r_vld;

endmodule

// File: tb/tb_alu_cu.sv
// Directed plus random bench for alu_cu against a table-driven reference model.
// Checks illegal only when ALU_CU_ILLEGAL_EN is defined.
module tb_alu_cu;

    logic       clk;
    logic       clk_en;
    logic       rst_n;
    logic [1:0] alu_op;
    logic [1:0] f3;
    logic [1:0] f7;
    logic       in_valid;
    logic [3:0] control_i;
    logic       out_valid;
`ifdef ALU_CU_ILLEGAL_EN
    logic       illegal;
`endif

    int n_chk = 0;
    int n_err = 0;

    logic [3:0] exp_code;
    logic       exp_vld;
    logic       exp_ill;

    typedef struct {
        logic [1:0] f7;
        logic [1:0] f3;
        logic [3:0] code;
    } rent_t;

    // The only legal R-type (f7,f3) pairs and their codes.
    rent_t rtab [5] = '{
        '{2'b00, 2'b00, 4'b0010},
        '{2'b01, 2'b00, 4'b0110},
        '{2'b00, 2'b01, 4'b0111},
        '{2'b00, 2'b10, 4'b0001},
        '{2'b00, 2'b11, 4'b0000}
    };

    alu_cu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_op    (alu_op),
        .f3        (f3),
        .f7        (f7),
        .in_valid  (in_valid),
        .control_i (control_i),
        .out_valid (out_valid)
`ifdef ALU_CU_ILLEGAL_EN
        ,
        .illegal   (illegal)
`endif
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    function automatic void ref_decode(input logic [1:0] op, input logic [1:0] fn3,
                                       input logic [1:0] fn7,
                                       output logic [3:0] c, output logic ill);
        c   = 4'b0010;
        ill = 1'b1;
        if (op == 2'd0) begin
            ill = 1'b0;
        end else if (op == 2'd1) begin
            c   = 4'b0110;
            ill = 1'b0;
        end else if (op == 2'd2) begin
            foreach (rtab[i]) begin
                if (rtab[i].f7 == fn7 && rtab[i].f3 == fn3) begin
                    c   = rtab[i].code;
                    ill = 1'b0;
                end
            end
        end
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".code"}, control_i, exp_code);
        check({tag, ".vld"}, {3'b0, out_valid}, {3'b0, exp_vld});
`ifdef ALU_CU_ILLEGAL_EN
        check({tag, ".ill"}, {3'b0, illegal}, {3'b0, exp_ill});
`endif
    endtask

    task automatic step(input string tag, input logic [1:0] op, input logic [1:0] fn3,
                        input logic [1:0] fn7, input logic vld);
        logic [3:0] c;
        logic       ill;
        @(negedge clk);
        alu_op   = op;
        f3       = fn3;
        f7       = fn7;
        in_valid = vld;
        @(posedge clk);
        #1;
        if (vld) begin
            ref_decode(op, fn3, fn7, c, ill);
            exp_code = c;
            exp_ill  = ill;
        end
        exp_vld = vld;
        check_all(tag);
    endtask

    initial begin
        clk      = 1'b0;
        clk_en   = 1'b0;
        rst_n    = 1'b1;
        alu_op   = 2'b00;
        f3       = 2'b00;
        f7       = 2'b00;
        in_valid = 1'b0;

        // Reset with no clock running.
        #2 rst_n = 1'b0;
        #1;
        exp_code = 4'b0010;
        exp_vld  = 1'b0;
        exp_ill  = 1'b0;
        check_all("reset_noclk");

        clk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Load/store and branch with funct fields unknown.
        step("ls_x", 2'b00, 2'bxx, 2'bxx, 1'b1);
        check("ls_x.known", {3'b0, $isunknown(control_i)}, 4'b0);
        step("br_x", 2'b01, 2'bxx, 2'bxx, 1'b1);
        check("br_x.known", {3'b0, $isunknown(control_i)}, 4'b0);

        step("r_add", 2'b10, 2'b00, 2'b00, 1'b1);
        step("r_sub", 2'b10, 2'b00, 2'b01, 1'b1);
        step("r_and", 2'b10, 2'b11, 2'b00, 1'b1);
        step("r_or",  2'b10, 2'b10, 2'b00, 1'b1);
        step("r_slt", 2'b10, 2'b01, 2'b00, 1'b1);

        step("ill_rsv",   2'b11, 2'b11, 2'b00, 1'b1);
        step("ill_f7_10", 2'b10, 2'b11, 2'b10, 1'b1);
        step("ill_alt",   2'b10, 2'b10, 2'b01, 1'b1);

        // Idle after AND holds the code.
        step("and_again", 2'b10, 2'b11, 2'b00, 1'b1);
        step("hold0", 2'b01, 2'b00, 2'b00, 1'b0);
        step("hold1", 2'b00, 2'b01, 2'b11, 1'b0);

        // Asynchronous reset pulse between two valid inputs.
        step("pre_rst", 2'b01, 2'b00, 2'b00, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        exp_code = 4'b0010;
        exp_vld  = 1'b0;
        exp_ill  = 1'b0;
        check_all("mid_rst");
        #1 rst_n = 1'b1;
        step("post_rst", 2'b10, 2'b11, 2'b00, 1'b1);

        for (int i = 0; i < 300; i++) begin
            step("rand", 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/alu_cu.md
ALU_CU -- requirements
Module: alu_cu

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port alu_op, input, 2 bits: main-decoder class (00 load/store, 01 branch, 10 R-type, 11 reserved).
REQ-005 Port f3, input, 2 bits: compressed funct3 (00 add/sub, 01 slt, 10 or, 11 and).
REQ-006 Port f7, input, 2 bits: compressed funct7 (00 normal, 01 alternate/sub, 1x reserved).
REQ-007 Port in_valid, input, 1 bit: the inputs are valid this cycle.
REQ-008 Port control_i, output, 4 bits: registered ALU operation code.
REQ-009 Port out_valid, output, 1 bit: control_i holds a result decoded from a valid input.
REQ-010 Port illegal, output, 1 bit, present only with ALU_CU_ILLEGAL_EN: the registered code came from an unsupported encoding.

Function
REQ-011 Codes SHALL be AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
REQ-012 alu_op=00 SHALL decode to ADD regardless of f3/f7.
REQ-013 alu_op=01 SHALL decode to SUB regardless of f3/f7.
REQ-014 alu_op=10 decode: f7=00,f3=00 -> ADD; f7=01,f3=00 -> SUB; f7=00,f3=01 -> SLT; f7=00,f3=10 -> OR; f7=00,f3=11 -> AND.
REQ-015 Illegal encodings are alu_op=11, alu_op=10 with f7=1x, and alu_op=10 with f7=01 and f3!=00; each SHALL decode to ADD (0010) and be flagged illegal.
REQ-016 Latency SHALL be one cycle: inputs sampled on rising clk edge N appear on control_i and out_valid after edge N.
REQ-017 When in_valid=1 at an edge, control_i (and illegal) SHALL load the decoded value and out_valid SHALL be 1.
REQ-018 When in_valid=0 at an edge, control_i and illegal SHALL hold their previous values and out_valid SHALL be 0.
REQ-019 X/Z on f3/f7 SHALL NOT propagate when alu_op is 00 or 01.
REQ-020 There SHALL be no backpressure; every valid input is accepted every cycle.

Reset
REQ-021 While rst_n=0: control_i=0010, out_valid=0, illegal=0, applied immediately without waiting for a clock edge.
REQ-022 Reset asserted mid-stream SHALL discard any result in flight; the first valid input after release SHALL be sampled on the first rising edge with rst_n=1.

Configuration
REQ-023 Macro ALU_CU_ILLEGAL_EN defined: the illegal output port and its register SHALL exist.
REQ-024 Macro ALU_CU_ILLEGAL_EN undefined: no illegal port; illegal encodings SHALL still decode to ADD.

Structure
REQ-025 Package alu_cu_pkg SHALL hold the ALU code constants (AND/OR/ADD/SUB/SLT), the alu_op class constants, and the f3/f7 encoding constants.
REQ-026 Decoding SHALL live in combinational sub-module alu_cu_dec (inputs alu_op/f3/f7; outputs code and illegal); alu_cu SHALL add the registers and the valid logic around it.

Verification
REQ-027 Assert rst_n=0 with no clock -> control_i=0010, out_valid=0 immediately.
REQ-028 alu_op=00 then 01 with in_valid=1, f3/f7 left X -> control_i 0010 then 0110, one cycle after each input, no X.
REQ-029 alu_op=10 sequence (f7,f3) = (00,00), (01,00), (00,11), (00,10), (00,01) -> control_i 0010, 0110, 0000, 0001, 0111 on consecutive cycles.
REQ-030 alu_op=11, and alu_op=10 with f7=10 -> control_i=0010; illegal=1 only with ALU_CU_ILLEGAL_EN.
REQ-031 Drop in_valid to 0 after an AND result -> control_i stays 0000, out_valid=0.
REQ-032 Pulse rst_n low between two valid inputs -> the outputs return to reset values asynchronously and the next valid input decodes correctly.
